matrix_load_ctrl: RTL and testbench
===================================

MATRIX_LOAD_CTRL -- requirements
Module: matrix_load_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): FILE_SIZE, 16, register-file depth.
REQ-002 Parameter: DATA_SIZE, 4, data-matrix rows.
REQ-003 Parameter: WEIGHT_SIZE, 4, weight-matrix rows.
REQ-004 Parameter: DATA_BASE, 5, register index of data row 0.
REQ-005 Parameter: TIMEOUT, 255, max cycles waiting for mac_done_i.
REQ-006 Ports SHALL be (name, direction, width, meaning): clk_i, in, 1, single clock; reset, in, 1, synchronous active-high reset.
REQ-007 start_i, in, 1, request a load-and-compute sequence.
REQ-008 ld_valid_i, in, 1; ld_data_i, in, 32; ld_ready_o, out, 1: row stream, data rows first, then weight rows.
REQ-009 cpu_we_i, in, 1; cpu_addr_i, in, 5; cpu_data_i, in, 32; cpu_pos_i, in, 4: core writeback request.
REQ-010 RegWrite_o, out, 1; RDaddr_o, out, 5; RDdata_o, out, 32; is_pos_o, out, 4: register-file write port.
REQ-011 mac_start_o, out, 1, compute start pulse; mac_done_i, in, 1, compute complete.
REQ-012 busy_o, out, 1; done_o, out, 1; err_o, out, 1; conflict_o, out, 1.

Function
REQ-013 FSM states SHALL be IDLE, LOAD_DATA, LOAD_WEIGHT, COMPUTE, WAIT, DONE, ERR; row counter row_cnt, timeout counter tmo_cnt.
REQ-014 IDLE: start_i=1 -> LOAD_DATA next cycle, row_cnt=0; busy_o=1 in every state except IDLE.
REQ-015 start_i while not IDLE SHALL be ignored.
REQ-016 ld_ready_o = (state is LOAD_DATA or LOAD_WEIGHT) and !cpu_we_i; transfer = ld_valid_i & ld_ready_o.
REQ-017 Write port SHALL be combinational, zero latency: cpu_we_i=1 -> RegWrite_o=1, RDaddr_o=cpu_addr_i, RDdata_o=cpu_data_i, is_pos_o=cpu_pos_i; else transfer -> RegWrite_o=1, RDdata_o=ld_data_i, is_pos_o=0; else all write-port outputs 0.
REQ-018 CPU SHALL always win arbitration; stalled stream data is held by the source (valid stays high, data stable).
REQ-019 LOAD_DATA transfer address = DATA_BASE+row_cnt; after row DATA_SIZE-1 -> LOAD_WEIGHT, row_cnt=0.
REQ-020 LOAD_WEIGHT transfer address = FILE_SIZE-1-row_cnt (row 0 -> 15); after row WEIGHT_SIZE-1 -> COMPUTE.
REQ-021 COMPUTE: mac_start_o=1 for exactly one cycle, -> WAIT, tmo_cnt=0.
REQ-022 WAIT: mac_done_i=1 -> DONE; else tmo_cnt++; tmo_cnt reaching TIMEOUT -> ERR.
REQ-023 DONE: done_o=1 one cycle, -> IDLE. ERR: err_o=1 held until reset; start_i ignored.
REQ-024 conflict_o SHALL pulse one cycle when cpu_we_i=1 in a LOAD state and cpu_addr_i lies in DATA_BASE..DATA_BASE+DATA_SIZE-1 or FILE_SIZE-WEIGHT_SIZE..FILE_SIZE-1; the CPU write still proceeds.
REQ-025 mac_done_i outside WAIT SHALL be ignored.
REQ-026 Counters SHALL be wide enough for max(DATA_SIZE, WEIGHT_SIZE) and TIMEOUT; no wrap inside a state.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, counters 0, ld_ready_o, mac_start_o, busy_o, done_o, err_o, conflict_o = 0, from any state including mid-load.
REQ-028 During reset, write-port outputs SHALL reflect only cpu_we_i passthrough (no stream writes).

Structure
REQ-029 State encoding and the DATA_BASE/FILE_SIZE/WEIGHT_SIZE defaults SHALL live in a shared package used with the register file.
REQ-030 No sub-module is required; arbitration mux and FSM live in one module.

Verification
REQ-031 Reset, start_i pulse, 8 rows 32'h11111111..32'h88888888 with valid held high -> writes to regs 5,6,7,8,15,14,13,12 on 8 consecutive cycles, then mac_start_o one pulse.
REQ-032 cpu_we_i=1 (addr 2, data 32'hDEADBEEF) during row 3 -> reg 2 written, ld_ready_o=0 that cycle, row 3 written the next cycle, conflict_o=0.
REQ-033 CPU writes reg 13 during LOAD_WEIGHT -> conflict_o pulses, RDaddr_o=13 with CPU data.
REQ-034 mac_done_i asserted 10 cycles after mac_start_o -> done_o pulse on the next cycle, busy_o=0 the cycle after.
REQ-035 mac_done_i never asserted -> err_o=1 after TIMEOUT cycles in WAIT; start_i ignored until reset.
REQ-036 reset asserted after 2 rows loaded -> IDLE next cycle, ld_ready_o=0; new start_i reloads from reg 5.

Source files
------------

// File: rtl/matrix_load_ctrl_pkg.sv
// Shared definitions for the matrix load controller and the register file it feeds.
package matrix_load_ctrl_pkg;

  localparam int unsigned FileSizeDef   = 16;
  localparam int unsigned DataSizeDef   = 4;
  localparam int unsigned WeightSizeDef = 4;
  localparam int unsigned DataBaseDef   = 5;

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StLoadData   = 3'd1;
  localparam logic [2:0] StLoadWeight = 3'd2;
  localparam logic [2:0] StCompute    = 3'd3;
  localparam logic [2:0] StWait       = 3'd4;
  localparam logic [2:0] StDone       = 3'd5;
  localparam logic [2:0] StErr        = 3'd6;

  function automatic logic in_window(input int unsigned addr, input int unsigned lo,
                                     input int unsigned len);
    return (addr >= lo) && (addr < lo + len);
  endfunction

endpackage

// File: rtl/matrix_load_ctrl.sv
// Streams data and weight rows into the register file, arbitrating against core
// writeback, then launches the MAC and supervises its completion with a timeout.
module matrix_load_ctrl
  import matrix_load_ctrl_pkg::*;
#(
  parameter int unsigned FILE_SIZE   = FileSizeDef,
  parameter int unsigned DATA_SIZE   = DataSizeDef,
  parameter int unsigned WEIGHT_SIZE = WeightSizeDef,
  parameter int unsigned DATA_BASE   = DataBaseDef,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        start_i,
  input  logic        ld_valid_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  input  logic        cpu_we_i,
  input  logic [4:0]  cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_pos_i,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic [3:0]  is_pos_o,
  output logic        mac_start_o,
  input  logic        mac_done_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        conflict_o
);

  localparam int unsigned MaxRows = (DATA_SIZE > WEIGHT_SIZE) ? DATA_SIZE : WEIGHT_SIZE;
  localparam int unsigned RowW    = $clog2(MaxRows + 1);
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

  logic [2:0]      state_q, state_d;
  logic [RowW-1:0] row_cnt_q, row_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            in_load;
  logic            transfer;
  logic [4:0]      ld_addr;

  assign in_load  = (state_q == StLoadData) || (state_q == StLoadWeight);
  // Stream writes are suppressed while reset is held so only CPU writeback passes.
  assign ld_ready_o = in_load && !cpu_we_i && !reset;
  assign transfer   = ld_valid_i && ld_ready_o;

  always_comb begin
    if (state_q == StLoadData) begin
      ld_addr = 5'(DATA_BASE + int'(row_cnt_q));
    end else begin
      ld_addr = 5'(FILE_SIZE - 1 - int'(row_cnt_q));
    end
  end

  always_comb begin
    RegWrite_o = 1'b0;
    RDaddr_o   = '0;
    RDdata_o   = '0;
    is_pos_o   = '0;
    if (cpu_we_i) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = cpu_addr_i;
      RDdata_o   = cpu_data_i;
      is_pos_o   = cpu_pos_i;
    end else if (transfer) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = ld_addr;
      RDdata_o   = ld_data_i;
    end
  end

  assign conflict_o = in_load && cpu_we_i && !reset &&
                      (in_window(int'(cpu_addr_i), DATA_BASE, DATA_SIZE) ||
                       in_window(int'(cpu_addr_i), FILE_SIZE - WEIGHT_SIZE, WEIGHT_SIZE));

  assign busy_o      = (state_q != StIdle);
  assign mac_start_o = (state_q == StCompute);
  assign done_o      = (state_q == StDone);
  assign err_o       = (state_q == StErr);

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StLoadData;
          row_cnt_d = '0;
        end
      end
      StLoadData: begin
        if (transfer) begin
          if (row_cnt_q == RowW'(DATA_SIZE - 1)) begin
            state_d   = StLoadWeight;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      StLoadWeight: begin
        if (transfer) begin
          if (row_cnt_q == RowW'(WEIGHT_SIZE - 1)) begin
            state_d   = StCompute;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      StCompute: begin
        state_d   = StWait;
        tmo_cnt_d = '0;
      end
      StWait: begin
        if (mac_done_i) begin
          state_d = StDone;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
            state_d = StErr;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Directed bench for matrix_load_ctrl: full load, CPU arbitration, completion,
// timeout and mid-load reset.
module tb_matrix_load_ctrl;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        start_i;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic        cpu_we_i;
  logic [4:0]  cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [3:0]  cpu_pos_i;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic [3:0]  is_pos_o;
  logic        mac_start_o;
  logic        mac_done_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        conflict_o;

  int total = 0;
  int bad   = 0;

  matrix_load_ctrl dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .start_i     (start_i),
    .ld_valid_i  (ld_valid_i),
    .ld_data_i   (ld_data_i),
    .ld_ready_o  (ld_ready_o),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_pos_i   (cpu_pos_i),
    .RegWrite_o  (RegWrite_o),
    .RDaddr_o    (RDaddr_o),
    .RDdata_o    (RDdata_o),
    .is_pos_o    (is_pos_o),
    .mac_start_o (mac_start_o),
    .mac_done_i  (mac_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .conflict_o  (conflict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] row_data(input int i);
    return 32'h11111111 * 32'(i + 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_addr [8];
    exp_addr = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd14, 5'd13, 5'd12};

    reset = 1'b1; start_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = '0;
    cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_pos_i = '0; mac_done_i = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(ld_ready_o), 32'd0);
    chk("rst_flags", {28'd0, done_o, err_o, mac_start_o, conflict_o}, 32'd0);
    chk("rst_we", 32'(RegWrite_o), 32'd0);

    // Full load with valid held high.
    tick();
    reset = 1'b0; start_i = 1'b1;
    #1;
    chk("idle_busy", 32'(busy_o), 32'd0);
    tick();
    start_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = row_data(0);
    #1;
    chk("load_busy", 32'(busy_o), 32'd1);
    chk("load_ready", 32'(ld_ready_o), 32'd1);
    chk("row0_we", 32'(RegWrite_o), 32'd1);
    chk("row0_addr", 32'(RDaddr_o), 32'd5);
    chk("row0_data", RDdata_o, 32'h11111111);
    chk("row0_pos", 32'(is_pos_o), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      ld_data_i = row_data(i);
      #1;
      chk("row_we", 32'(RegWrite_o), 32'd1);
      chk("row_addr", 32'(RDaddr_o), 32'(exp_addr[i]));
      chk("row_data", RDdata_o, row_data(i));
    end
    tick();
    ld_valid_i = 1'b0;
    #1;
    chk("mac_start", 32'(mac_start_o), 32'd1);
    chk("compute_we", 32'(RegWrite_o), 32'd0);
    tick();
    #1;
    chk("mac_start_pulse", 32'(mac_start_o), 32'd0);
    for (int j = 2; j < 10; j++) tick();
    tick();
    mac_done_i = 1'b1;
    #1;
    chk("done_early", 32'(done_o), 32'd0);
    tick();
    mac_done_i = 1'b0;
    #1;
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd1);
    tick();
    #1;
    chk("done_clear", 32'(done_o), 32'd0);
    chk("idle_after_done", 32'(busy_o), 32'd0);

    // CPU writeback during a load: non-conflicting then conflicting address.
    start_i = 1'b1;
    tick();
    start_i = 1'b0; ld_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_data_i = row_data(i);
      tick();
    end
    ld_data_i = row_data(3);
    cpu_we_i = 1'b1; cpu_addr_i = 5'd2; cpu_data_i = 32'hDEADBEEF; cpu_pos_i = 4'h5;
    #1;
    chk("cpu_we", 32'(RegWrite_o), 32'd1);
    chk("cpu_addr", 32'(RDaddr_o), 32'd2);
    chk("cpu_data", RDdata_o, 32'hDEADBEEF);
    chk("cpu_pos", 32'(is_pos_o), 32'h5);
    chk("cpu_stall", 32'(ld_ready_o), 32'd0);
    chk("cpu_noconflict", 32'(conflict_o), 32'd0);
    tick();
    cpu_we_i = 1'b0;
    #1;
    chk("row3_addr", 32'(RDaddr_o), 32'd8);
    chk("row3_data", RDdata_o, 32'h44444444);
    chk("row3_ready", 32'(ld_ready_o), 32'd1);
    for (int i = 4; i < 6; i++) begin
      tick();
      ld_data_i = row_data(i);
    end
    tick();
    ld_data_i = row_data(6);
    cpu_we_i = 1'b1; cpu_addr_i = 5'd13; cpu_data_i = 32'hCAFEF00D;
    #1;
    chk("conflict", 32'(conflict_o), 32'd1);
    chk("conflict_addr", 32'(RDaddr_o), 32'd13);
    chk("conflict_data", RDdata_o, 32'hCAFEF00D);
    tick();
    cpu_we_i = 1'b0;
    #1;
    chk("conflict_pulse", 32'(conflict_o), 32'd0);
    chk("row6_addr", 32'(RDaddr_o), 32'd13);
    chk("row6_data", RDdata_o, 32'h77777777);
    tick();
    ld_data_i = row_data(7);
    tick();
    ld_valid_i = 1'b0; mac_done_i = 1'b1;
    #1;
    chk("mac_start2", 32'(mac_start_o), 32'd1);

    // mac_done in COMPUTE must be ignored; then let WAIT time out.
    tick();
    mac_done_i = 1'b0;
    #1;
    chk("done_ignored", 32'(done_o), 32'd0);
    chk("wait_busy", 32'(busy_o), 32'd1);
    repeat (254) tick();
    #1;
    chk("pre_timeout_err", 32'(err_o), 32'd0);
    tick();
    #1;
    chk("timeout_err", 32'(err_o), 32'd1);
    start_i = 1'b1;
    tick();
    tick();
    #1;
    chk("err_sticky", 32'(err_o), 32'd1);
    chk("err_busy", 32'(busy_o), 32'd1);
    chk("err_ready", 32'(ld_ready_o), 32'd0);
    start_i = 1'b0;

    // Reset clears ERR; then reset mid-load and reload.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("err_reset", 32'(err_o), 32'd0);
    chk("err_reset_busy", 32'(busy_o), 32'd0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = row_data(0);
    tick();
    ld_data_i = row_data(1);
    tick();
    ld_data_i = row_data(2); reset = 1'b1;
    #1;
    chk("rst_no_stream", 32'(RegWrite_o), 32'd0);
    chk("rst_ready_low", 32'(ld_ready_o), 32'd0);
    cpu_we_i = 1'b1; cpu_addr_i = 5'd3; cpu_data_i = 32'h12345678;
    #1;
    chk("rst_cpu_we", 32'(RegWrite_o), 32'd1);
    chk("rst_cpu_addr", 32'(RDaddr_o), 32'd3);
    cpu_we_i = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("midload_idle", 32'(busy_o), 32'd0);
    chk("midload_ready", 32'(ld_ready_o), 32'd0);
    chk("midload_we", 32'(RegWrite_o), 32'd0);
    start_i = 1'b1; ld_valid_i = 1'b0;
    tick();
    start_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = row_data(0);
    #1;
    chk("reload_we", 32'(RegWrite_o), 32'd1);
    chk("reload_addr", 32'(RDaddr_o), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
